player_bullet_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 31 +++
 rtl/player_bullet_ctrl_if.sv | 27 ++
 rtl/slot_alloc.sv | 23 ++
 rtl/player_bullet_ctrl.sv | 125 ++++++++++++
 tb/tb_player_bullet_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game-wide constants, position packing helpers and the fire FSM states.
package game_pkg;

   localparam int POS_X_W  = 10;
   localparam int POS_Y_W  = 9;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Packed on-screen position: x in the upper field, y in the lower field.
   typedef logic [POS_X_W+POS_Y_W-1:0] pos_t;

   typedef enum logic [1:0] {
      READY    = 2'd0,
      ARMED    = 2'd1,
      COOLDOWN = 2'd2
   } fire_state_e;

   function automatic pos_t pos_pack(input logic [POS_X_W-1:0] x,
                                     input logic [POS_Y_W-1:0] y);
      return {x, y};
   endfunction

   function automatic logic [POS_X_W-1:0] pos_x(input pos_t p);
      return p[POS_X_W+POS_Y_W-1:POS_Y_W];
   endfunction

   function automatic logic [POS_Y_W-1:0] pos_y(input pos_t p);
      return p[POS_Y_W-1:0];
   endfunction

endpackage

// File: rtl/player_bullet_ctrl_if.sv
// Frame/fire/hit inputs and bullet-pool outputs of the player bullet controller.
interface player_bullet_ctrl_if
   import game_pkg::*;
#(
   parameter int N = 15
);
   logic               i_FrameTick;
   logic               i_Fire;
   logic               i_PlayerState;
   logic [POS_X_W-1:0] i_PlayerPosition;
   logic [N-1:0]       i_HitMask;
   logic [N-1:0]       o_PlayerBulletState;
   pos_t               o_PlayerBulletPosition [N];
   logic               o_FireAccepted;

   // Game logic side: drives frame/fire/hit, observes the pool.
   modport master (
      output i_FrameTick, i_Fire, i_PlayerState, i_PlayerPosition, i_HitMask,
      input  o_PlayerBulletState, o_PlayerBulletPosition, o_FireAccepted
   );

   // Bullet controller side.
   modport slave (
      input  i_FrameTick, i_Fire, i_PlayerState, i_PlayerPosition, i_HitMask,
      output o_PlayerBulletState, o_PlayerBulletPosition, o_FireAccepted
   );
endinterface

// File: rtl/slot_alloc.sv
// Lowest-index free-slot finder; purely combinational.
module slot_alloc #(
   parameter  int N     = 15,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_Free,
   output logic [IDX_W-1:0] o_Idx,
   output logic             o_Found
);

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      o_Idx   = '0;
      o_Found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_Free[i]) begin
            o_Idx   = IDX_W'(i);
            o_Found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Player bullet pool: spawns on fire edges, moves up each frame, retires at the
// screen top or on a collision hit.
module player_bullet_ctrl
   import game_pkg::*;
#(
   parameter int MAX_PLAYER_BULLET = 15,
   parameter int BULLET_SPEED      = 4,
   parameter int FIRE_COOLDOWN     = 8,
   parameter int PLAYER_Y          = 440
) (
   input logic                 i_Clk,
   input logic                 i_Rst,
   player_bullet_ctrl_if.slave bus
);

   localparam int N     = MAX_PLAYER_BULLET;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

   localparam logic [POS_Y_W-1:0] SPEED_Y    = POS_Y_W'(BULLET_SPEED);
   localparam logic [POS_Y_W-1:0] SPAWN_Y    = POS_Y_W'(PLAYER_Y);
   localparam logic [CNT_W-1:0]   COOLDOWN_V = CNT_W'(FIRE_COOLDOWN);

   fire_state_e      fsm_q, fsm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fire_prev_q;
   logic             fire_acc_q, fire_acc_d;
   logic [N-1:0]     alive_q, alive_d;
   pos_t             pos_q [N];
   pos_t             pos_d [N];

   logic             fire_edge;
   logic             spawn;
   logic [N-1:0]     free_vec;
   logic [IDX_W-1:0] free_idx;
   logic             free_found;

   // A slot being hit this cycle is still occupied until the next edge.
   assign free_vec = ~alive_q & ~bus.i_HitMask;

   slot_alloc #(.N(N)) u_alloc (
      .i_Free  (free_vec),
      .o_Idx   (free_idx),
      .o_Found (free_found)
   );

   // Fire FSM: edge arms, next frame tick spawns, then a frame-counted cooldown.
   always_comb begin
      fsm_d     = fsm_q;
      cnt_d     = cnt_q;
      spawn     = 1'b0;
      fire_edge = bus.i_Fire & ~fire_prev_q;
      case (fsm_q)
         READY: begin
            if (fire_edge && bus.i_PlayerState) fsm_d = ARMED;
         end
         ARMED: begin
            if (!bus.i_PlayerState) begin
               fsm_d = READY;
            end else if (bus.i_FrameTick) begin
               if (free_found) begin
                  spawn = 1'b1;
                  fsm_d = COOLDOWN;
                  cnt_d = COOLDOWN_V;
               end else begin
                  fsm_d = READY;
               end
            end
         end
         COOLDOWN: begin
            if (cnt_q == '0) begin
               fsm_d = READY;
            end else if (bus.i_FrameTick) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) fsm_d = READY;
            end
         end
         default: fsm_d = READY;
      endcase
      fire_acc_d = spawn;
   end

   // Per-slot update: hit beats movement; top exit clears without wrapping y.
   always_comb begin
      alive_d = alive_q;
      pos_d   = pos_q;
      for (int n = 0; n < N; n++) begin
         if (alive_q[n]) begin
            if (bus.i_HitMask[n]) begin
               alive_d[n] = 1'b0;
            end else if (bus.i_FrameTick) begin
               if (pos_y(pos_q[n]) < SPEED_Y) alive_d[n] = 1'b0;
               else pos_d[n] = pos_pack(pos_x(pos_q[n]), pos_y(pos_q[n]) - SPEED_Y);
            end
         end else if (spawn && (IDX_W'(n) == free_idx)) begin
            alive_d[n] = 1'b1;
            pos_d[n]   = pos_pack(bus.i_PlayerPosition, SPAWN_Y);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         fsm_q       <= READY;
         cnt_q       <= '0;
         fire_prev_q <= 1'b0;
         fire_acc_q  <= 1'b0;
         alive_q     <= '0;
         for (int n = 0; n < N; n++) pos_q[n] <= '0;
      end else begin
         fsm_q       <= fsm_d;
         cnt_q       <= cnt_d;
         fire_prev_q <= bus.i_Fire;
         fire_acc_q  <= fire_acc_d;
         alive_q     <= alive_d;
         for (int n = 0; n < N; n++) pos_q[n] <= pos_d[n];
      end
   end

   assign bus.o_PlayerBulletState    = alive_q;
   assign bus.o_PlayerBulletPosition = pos_q;
   assign bus.o_FireAccepted         = fire_acc_q;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Bench for player_bullet_ctrl: a default instance (A) and a short-cooldown,
// odd-spawn-row instance (B) share stimulus; both are tracked by a pool model.
module tb_player_bullet_ctrl;

   localparam int NS = 15;

   logic          clk;
   logic          rst, tick, fire, ps;
   logic [9:0]    px;
   logic [NS-1:0] hit;

   player_bullet_ctrl_if #(.N(NS)) bus_a ();
   player_bullet_ctrl_if #(.N(NS)) bus_b ();

   assign bus_a.i_FrameTick = tick;      assign bus_b.i_FrameTick = tick;
   assign bus_a.i_Fire = fire;           assign bus_b.i_Fire = fire;
   assign bus_a.i_PlayerState = ps;      assign bus_b.i_PlayerState = ps;
   assign bus_a.i_PlayerPosition = px;   assign bus_b.i_PlayerPosition = px;
   assign bus_a.i_HitMask = hit;         assign bus_b.i_HitMask = hit;

   player_bullet_ctrl #(.MAX_PLAYER_BULLET(NS)) dut_a (
      .i_Clk (clk), .i_Rst (rst), .bus (bus_a));

   player_bullet_ctrl #(.MAX_PLAYER_BULLET(NS), .BULLET_SPEED(4),
                        .FIRE_COOLDOWN(1), .PLAYER_Y(441)) dut_b (
      .i_Clk (clk), .i_Rst (rst), .bus (bus_b));

   logic [NS-1:0] st_o  [2];
   logic [18:0]   pos_o [2][NS];
   logic          acc_o [2];
   assign st_o[0] = bus_a.o_PlayerBulletState;     assign st_o[1] = bus_b.o_PlayerBulletState;
   assign pos_o[0] = bus_a.o_PlayerBulletPosition; assign pos_o[1] = bus_b.o_PlayerBulletPosition;
   assign acc_o[0] = bus_a.o_FireAccepted;         assign acc_o[1] = bus_b.o_FireAccepted;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   // Reference pool: per instance, plain bullet list plus "request pending"
   // and "frames left before the gun is usable".
   int        CD [2] = '{8, 1};
   int        PY [2] = '{440, 441};
   string     NM [2] = '{"A", "B"};
   bit        m_alive [2][NS];
   logic [9:0] m_x [2][NS];
   int        m_y [2][NS];
   bit        m_pend [2];
   int        m_cool [2];
   bit        m_prev [2];
   bit        m_acc  [2];

   function automatic logic [18:0] P(input int x, input int y);
      logic [9:0] xv;
      logic [8:0] yv;
      xv = 10'(x);
      yv = 9'(y);
      return {xv, yv};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
   endtask

   task automatic model_step();
      int  fr;
      bit  sp;
      bit  edge_seen;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int n = 0; n < NS; n++) begin
               m_alive[k][n] = 0; m_x[k][n] = '0; m_y[k][n] = 0;
            end
            m_pend[k] = 0; m_cool[k] = 0; m_prev[k] = 0; m_acc[k] = 0;
         end else begin
            fr = -1;
            for (int n = 0; n < NS; n++)
               if (fr < 0 && !m_alive[k][n] && !hit[n]) fr = n;
            edge_seen = fire && !m_prev[k];
            sp = 0;
            if (m_pend[k]) begin
               if (!ps) m_pend[k] = 0;
               else if (tick) begin
                  m_pend[k] = 0;
                  if (fr >= 0) begin sp = 1; m_cool[k] = CD[k]; end
               end
            end else if (m_cool[k] > 0) begin
               if (tick) m_cool[k]--;
            end else if (edge_seen && ps) begin
               m_pend[k] = 1;
            end
            for (int n = 0; n < NS; n++) begin
               if (m_alive[k][n]) begin
                  if (hit[n]) m_alive[k][n] = 0;
                  else if (tick) begin
                     if (m_y[k][n] < 4) m_alive[k][n] = 0;
                     else m_y[k][n] -= 4;
                  end
               end
            end
            if (sp) begin
               m_alive[k][fr] = 1; m_x[k][fr] = px; m_y[k][fr] = PY[k];
            end
            m_acc[k]  = sp;
            m_prev[k] = fire;
         end
      end
   endtask

   task automatic compare_model();
      logic [NS-1:0] es;
      logic [18:0]   ep [NS];
      int bad;
      for (int k = 0; k < 2; k++) begin
         bad = 0;
         for (int n = NS - 1; n >= 0; n--) begin
            es[n] = m_alive[k][n];
            ep[n] = P(int'(m_x[k][n]), m_y[k][n]);
            if (pos_o[k][n] !== ep[n]) bad = n;
         end
         chk($sformatf("%s state", NM[k]), 32'(st_o[k]), 32'(es));
         chk($sformatf("%s pos[%0d]", NM[k], bad), 32'(pos_o[k][bad]), 32'(ep[bad]));
         chk($sformatf("%s fire_acc", NM[k]), 32'(acc_o[k]), 32'(m_acc[k]));
      end
   endtask

   // One clock: model follows the applied inputs, DUT sampled 1 unit after the edge.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic cyc(input bit r, input bit t, input bit f, input bit p,
                      input int xx, input logic [NS-1:0] h);
      rst = r; tick = t; fire = f; ps = p; px = 10'(xx); hit = h;
      step();
   endtask

   typedef struct {
      bit            rst, tick, fire, ps;
      int            x;
      logic [NS-1:0] hit;
      logic [NS-1:0] e_state;
      bit            e_acc;
      logic [18:0]   e_pos0, e_pos1;
   } vec_t;

   vec_t tbl [16];
   int   x7;

   initial begin
      rst = 1; tick = 0; fire = 0; ps = 1; px = '0; hit = '0;

      // Single fire, movement, cooldown, ignored edge, second shot, hit priority (instance A).
      tbl[0]  = '{1,0,0,1,  0, 15'h0, 15'h0, 0, 19'h0,       19'h0};
      tbl[1]  = '{0,0,1,1,320, 15'h0, 15'h0, 0, 19'h0,       19'h0};
      tbl[2]  = '{0,1,1,1,320, 15'h0, 15'h1, 1, P(320,440),  19'h0};
      tbl[3]  = '{0,0,1,1,320, 15'h0, 15'h1, 0, P(320,440),  19'h0};
      tbl[4]  = '{0,1,1,1,320, 15'h0, 15'h1, 0, P(320,436),  19'h0};
      tbl[5]  = '{0,0,0,1,320, 15'h0, 15'h1, 0, P(320,436),  19'h0};
      tbl[6]  = '{0,1,1,1,320, 15'h0, 15'h1, 0, P(320,432),  19'h0};
      tbl[7]  = '{0,1,0,1,320, 15'h0, 15'h1, 0, P(320,428),  19'h0};
      tbl[8]  = '{0,1,0,1,320, 15'h0, 15'h1, 0, P(320,424),  19'h0};
      tbl[9]  = '{0,1,0,1,320, 15'h0, 15'h1, 0, P(320,420),  19'h0};
      tbl[10] = '{0,1,0,1,320, 15'h0, 15'h1, 0, P(320,416),  19'h0};
      tbl[11] = '{0,1,0,1,320, 15'h0, 15'h1, 0, P(320,412),  19'h0};
      tbl[12] = '{0,1,0,1,320, 15'h0, 15'h1, 0, P(320,408),  19'h0};
      tbl[13] = '{0,0,1,1,100, 15'h0, 15'h1, 0, P(320,408),  19'h0};
      tbl[14] = '{0,1,1,1,100, 15'h0, 15'h3, 1, P(320,404),  P(100,440)};
      tbl[15] = '{0,1,0,1,100, 15'h1, 15'h2, 0, P(320,404),  P(100,436)};

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].rst, tbl[i].tick, tbl[i].fire, tbl[i].ps, tbl[i].x, tbl[i].hit);
         chk($sformatf("vec%0d state", i), 32'(st_o[0]), 32'(tbl[i].e_state));
         chk($sformatf("vec%0d acc", i),   32'(acc_o[0]), 32'(tbl[i].e_acc));
         chk($sformatf("vec%0d pos0", i),  32'(pos_o[0][0]), 32'(tbl[i].e_pos0));
         chk($sformatf("vec%0d pos1", i),  32'(pos_o[0][1]), 32'(tbl[i].e_pos1));
      end

      // Hit and spawn in the same cycle, dead player while armed, mid-flight reset.
      cyc(1,0,0,1,0,'0);
      chk("rst state", 32'(st_o[0]), 32'h0);
      cyc(0,0,1,1,50,'0);
      cyc(0,1,0,1,50,'0);
      chk("first shot acc", 32'(acc_o[0]), 32'h1);
      repeat (8) cyc(0,1,0,1,50,'0);
      cyc(0,0,1,1,60,'0);
      cyc(0,1,0,1,60,15'h1);
      chk("hitspawn state", 32'(st_o[0]), 32'h2);
      chk("hitspawn pos0 held", 32'(pos_o[0][0]), 32'(P(50,408)));
      chk("hitspawn pos1", 32'(pos_o[0][1]), 32'(P(60,440)));
      chk("hitspawn acc", 32'(acc_o[0]), 32'h1);
      repeat (8) cyc(0,1,0,1,60,'0);
      cyc(0,0,1,1,70,'0);
      cyc(0,1,0,0,70,'0);
      chk("dead acc", 32'(acc_o[0]), 32'h0);
      chk("dead state", 32'(st_o[0]), 32'h2);
      chk("dead pos1 moves", 32'(pos_o[0][1]), 32'(P(60,404)));
      cyc(0,1,0,1,70,'0);
      chk("dead request dropped", 32'(acc_o[0]), 32'h0);
      chk("dead pos1 y400", 32'(pos_o[0][1]), 32'(P(60,400)));
      cyc(1,1,1,1,70,15'h7fff);
      chk("midrst state", 32'(st_o[0]), 32'h0);
      chk("midrst pos1", 32'(pos_o[0][1]), 32'h0);
      chk("midrst acc", 32'(acc_o[0]), 32'h0);
      cyc(0,0,1,1,80,'0);
      cyc(0,1,0,1,80,'0);
      chk("post-rst shot acc", 32'(acc_o[0]), 32'h1);
      chk("post-rst shot pos0", 32'(pos_o[0][0]), 32'(P(80,440)));

      // Pool full on B, drop the request, free slot 7, refill it, then ride it to the top.
      cyc(1,0,0,1,0,'0);
      for (int i = 0; i < NS; i++) begin
         cyc(0,0,1,1,i*10,'0);
         cyc(0,1,0,1,i*10,'0);
         cyc(0,1,0,1,i*10,'0);
      end
      chk("B pool full", 32'(st_o[1]), 32'h7fff);
      cyc(0,0,1,1,200,'0);
      cyc(0,1,0,1,200,'0);
      chk("B full no acc", 32'(acc_o[1]), 32'h0);
      chk("B full state", 32'(st_o[1]), 32'h7fff);
      cyc(0,0,0,1,200,15'h0080);
      chk("B slot7 freed", 32'(st_o[1]), 32'h7f7f);
      cyc(0,1,0,1,200,'0);
      chk("B no stale request", 32'(acc_o[1]), 32'h0);
      x7 = 77;
      cyc(0,0,1,1,x7,'0);
      cyc(0,1,0,1,x7,'0);
      chk("B refill acc", 32'(acc_o[1]), 32'h1);
      chk("B refill state", 32'(st_o[1]), 32'h7fff);
      chk("B refill pos7", 32'(pos_o[1][7]), 32'(P(x7,441)));
      for (int i = 0; i < 200 && m_y[1][7] != 5; i++) cyc(0,1,0,1,x7,'0);
      chk("B slot7 reached y5", 32'(pos_o[1][7]), 32'(P(x7,5)));
      cyc(0,1,0,1,x7,'0);
      chk("B y1 alive", 32'(st_o[1][7]), 32'h1);
      chk("B y1 pos", 32'(pos_o[1][7]), 32'(P(x7,1)));
      cyc(0,1,0,1,x7,'0);
      chk("B top exit state", 32'(st_o[1][7]), 32'h0);
      chk("B top exit no wrap", 32'(pos_o[1][7]), 32'(P(x7,1)));

      // Randomised traffic against the pool model.
      cyc(1,0,0,1,0,'0);
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0,499) == 0),
             $urandom_range(0,1) == 1,
             $urandom_range(0,2) == 0,
             $urandom_range(0,7) != 0,
             int'($urandom_range(0,639)),
             ($urandom_range(0,3) == 0) ? (NS'($urandom) & NS'($urandom) & NS'($urandom)) : '0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
